// File: rtl/i2s_tx_scheduler.sv
// I2S transmit word scheduler: primes one left/right word pair, then keeps the TX channel fed,
// inserting zero words on source underrun, while generating WS from a per-slot bit counter.
module i2s_tx_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             sck_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic             cfg_2ch_i,
    input  logic [4:0]       cfg_wlen_i,
    input  logic [31:0]      l_data_i,
    input  logic             l_valid_i,
    output logic             l_ready_o,
    input  logic [31:0]      r_data_i,
    input  logic             r_valid_i,
    output logic             r_ready_o,
    output logic [31:0]      tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             ws_o,
    output logic             underrun_o,
    output logic [CNT_W-1:0] underrun_cnt_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME_L = 3'd1,
        S_PRIME_R = 3'd2,
        S_RUN     = 3'd3,
        S_STOP    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sel;
    logic             r_2ch;
    logic [4:0]       r_wlen;
    logic [4:0]       r_bcnt;
    logic             r_ws;
    logic             r_underrun;
    logic [CNT_W-1:0] r_ucnt;

    logic             w_sel_right;
    logic             w_src_valid;
    logic [31:0]      w_src_data;
    logic             w_hs;
    logic             w_prime;
    logic             w_wrap;
    logic             w_zero_hs;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Mono always reads the left source; stereo follows the alternating slot selector.
    assign w_sel_right = r_2ch & r_sel;
    assign w_src_valid = w_sel_right ? r_valid_i : l_valid_i;
    assign w_src_data  = w_sel_right ? r_data_i  : l_data_i;
    assign w_hs        = tx_valid_o & tx_ready_i;
    assign w_prime     = (r_state == S_PRIME_L) || (r_state == S_PRIME_R);
    assign w_wrap      = (r_bcnt == r_wlen);
    assign w_zero_hs   = (r_state == S_RUN) & w_hs & ~w_src_valid;

    assign ws_o           = r_ws;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_ucnt;
    assign busy_o         = (r_state != S_IDLE);

    // TX word path and source readies
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 32'd0;
        l_ready_o  = 1'b0;
        r_ready_o  = 1'b0;
        case (r_state)
            S_PRIME_L, S_PRIME_R: begin
                tx_valid_o = w_src_valid;
                tx_data_o  = w_src_data;
                if (w_sel_right) begin
                    r_ready_o = tx_ready_i;
                end else begin
                    l_ready_o = tx_ready_i;
                end
            end
            S_RUN: begin
                tx_valid_o = 1'b1;
                if (w_src_valid) begin
                    tx_data_o = w_src_data;
                    if (w_sel_right) begin
                        r_ready_o = tx_ready_i;
                    end else begin
                        l_ready_o = tx_ready_i;
                    end
                end else begin
                    tx_data_o = 32'd0;
                end
            end
            S_STOP: begin
                tx_valid_o = 1'b1;
            end
            default: begin
                tx_valid_o = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_en_i) w_state_nxt = S_PRIME_L;
                else          w_state_nxt = S_IDLE;
            end
            S_PRIME_L: begin
                if (!cfg_en_i) w_state_nxt = S_IDLE;
                else if (w_hs) w_state_nxt = S_PRIME_R;
                else           w_state_nxt = S_PRIME_L;
            end
            S_PRIME_R: begin
                if (!cfg_en_i) w_state_nxt = S_IDLE;
                else if (w_hs) w_state_nxt = S_RUN;
                else           w_state_nxt = S_PRIME_R;
            end
            S_RUN: begin
                if (!cfg_en_i) w_state_nxt = S_STOP;
                else           w_state_nxt = S_RUN;
            end
            S_STOP: begin
                // Drain ends only at the close of a right slot so the frame stays whole.
                if (w_wrap && r_ws) w_state_nxt = S_IDLE;
                else                w_state_nxt = S_STOP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration is frozen outside IDLE
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_2ch  <= 1'b0;
            r_wlen <= 5'd0;
        end else if (r_state == S_IDLE) begin
            r_2ch  <= cfg_2ch_i;
            r_wlen <= cfg_wlen_i;
        end else begin
            r_2ch  <= r_2ch;
            r_wlen <= r_wlen;
        end
    end

    // Slot selector alternates per accepted word
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sel <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_sel <= 1'b0;
        end else if (w_hs && ((r_state == S_RUN) || (w_prime && r_2ch))) begin
            r_sel <= ~r_sel;
        end else begin
            r_sel <= r_sel;
        end
    end

    // WS generator: counter and word select only advance while streaming or draining
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_bcnt <= 5'd0;
            r_ws   <= 1'b0;
        end else if ((r_state == S_RUN) || (r_state == S_STOP)) begin
            if (w_wrap) begin
                r_bcnt <= 5'd0;
                r_ws   <= ~r_ws;
            end else begin
                r_bcnt <= r_bcnt + 5'd1;
                r_ws   <= r_ws;
            end
        end else begin
            r_bcnt <= 5'd0;
            r_ws   <= 1'b0;
        end
    end

    // Underrun pulse and saturating count; only a reset clears the count
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_underrun <= w_zero_hs;
            if (w_zero_hs) begin
                r_ucnt <= sat_inc(r_ucnt);
            end else begin
                r_ucnt <= r_ucnt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: stereo prime, underrun, saturation, stop drain, mono, abort and reset.
module tb_i2s_tx_scheduler;

    logic        sck;
    logic        rstn;
    logic        en;
    logic        ch2;
    logic [4:0]  wlen;
    logic [31:0] ldata;
    logic        lvalid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        tready;

    logic        l_rdy, r_rdy, tx_v, ws, und, busy;
    logic [31:0] tx_d;
    logic [7:0]  ucnt;
    logic        l_rdy2, r_rdy2, tx_v2, ws2, und2, busy2;
    logic [31:0] tx_d2;
    logic [1:0]  ucnt2;

    int n_total = 0;
    int n_pass  = 0;
    int n_pulse2 = 0;

    i2s_tx_scheduler dut (
        .sck_i(sck), .rstn_i(rstn), .cfg_en_i(en), .cfg_2ch_i(ch2), .cfg_wlen_i(wlen),
        .l_data_i(ldata), .l_valid_i(lvalid), .l_ready_o(l_rdy),
        .r_data_i(rdata), .r_valid_i(rvalid), .r_ready_o(r_rdy),
        .tx_data_o(tx_d), .tx_valid_o(tx_v), .tx_ready_i(tready),
        .ws_o(ws), .underrun_o(und), .underrun_cnt_o(ucnt), .busy_o(busy)
    );

    i2s_tx_scheduler #(.CNT_W(2)) dut2 (
        .sck_i(sck), .rstn_i(rstn), .cfg_en_i(en), .cfg_2ch_i(ch2), .cfg_wlen_i(wlen),
        .l_data_i(ldata), .l_valid_i(lvalid), .l_ready_o(l_rdy2),
        .r_data_i(rdata), .r_valid_i(rvalid), .r_ready_o(r_rdy2),
        .tx_data_o(tx_d2), .tx_valid_o(tx_v2), .tx_ready_i(tready),
        .ws_o(ws2), .underrun_o(und2), .underrun_cnt_o(ucnt2), .busy_o(busy2)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    always @(negedge sck) begin
        if (und2 === 1'b1) n_pulse2 = n_pulse2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sck);
        #2;
    endtask

    initial begin
        rstn = 1'b1; en = 1'b0; ch2 = 1'b1; wlen = 5'd15;
        ldata = 32'hA; lvalid = 1'b1; rdata = 32'hB; rvalid = 1'b1; tready = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(tx_v), 32'd0);
        chk("rst_data", tx_d, 32'd0);
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ucnt", 32'(ucnt), 32'd0);
        chk("rst_lrdy", 32'(l_rdy), 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        en = 1'b1; #1;
        chk("idle_valid", 32'(tx_v), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Stereo prime: left then right word
        tick(); #1;
        chk("primeL_data", tx_d, 32'hA);
        chk("primeL_lrdy", 32'(l_rdy), 32'd1);
        chk("primeL_rrdy", 32'(r_rdy), 32'd0);
        chk("primeL_busy", 32'(busy), 32'd1);
        tick(); #1;
        chk("primeR_data", tx_d, 32'hB);
        chk("primeR_rrdy", 32'(r_rdy), 32'd1);
        chk("primeR_lrdy", 32'(l_rdy), 32'd0);
        tick(); #1;                               // RUN t=0
        chk("run0_data", tx_d, 32'hA);
        chk("run0_lrdy", 32'(l_rdy), 32'd1);
        chk("run0_ws", 32'(ws), 32'd0);
        tick(); #1;                               // t=1
        chk("run1_data", tx_d, 32'hB);
        chk("run1_rrdy", 32'(r_rdy), 32'd1);
        repeat (14) tick(); #1;                   // t=15
        chk("ws_t15", 32'(ws), 32'd0);
        tick(); #1;                               // t=16
        chk("ws_t16", 32'(ws), 32'd1);
        chk("run16_data", tx_d, 32'hA);
        repeat (15) tick(); #1;                   // t=31
        chk("ws_t31", 32'(ws), 32'd1);
        tick(); #1;                               // t=32
        chk("ws_t32", 32'(ws), 32'd0);

        // Underrun on a right slot
        tick();                                   // t=33
        rvalid = 1'b0; ldata = 32'h11; #1;
        chk("ur_data", tx_d, 32'd0);
        chk("ur_valid", 32'(tx_v), 32'd1);
        chk("ur_rrdy", 32'(r_rdy), 32'd0);
        chk("ur_lrdy", 32'(l_rdy), 32'd0);
        chk("ur_pulse0", 32'(und), 32'd0);
        tick();                                   // t=34
        rvalid = 1'b1; #1;
        chk("ur_pulse1", 32'(und), 32'd1);
        chk("ur_cnt1", 32'(ucnt), 32'd1);
        chk("ur_next_left", tx_d, 32'h11);
        chk("ur_next_lrdy", 32'(l_rdy), 32'd1);
        tick(); #1;                               // t=35
        chk("ur_pulse_end", 32'(und), 32'd0);
        chk("ur_right_back", tx_d, 32'hB);

        // Four more underruns: saturation on the narrow counter
        tick();                                   // t=36
        lvalid = 1'b0; rvalid = 1'b0; #1;
        chk("sat_zero_data", tx_d, 32'd0);
        chk("sat_zero_lrdy", 32'(l_rdy), 32'd0);
        repeat (4) tick();                        // t=40
        lvalid = 1'b1; rvalid = 1'b1; #1;
        chk("sat_cnt8", 32'(ucnt), 32'd5);
        chk("sat_cnt2", 32'(ucnt2), 32'd3);
        chk("sat_pulse_last", 32'(und2), 32'd1);

        // Stop while ws=0; re-enable during STOP is ignored
        tick();                                   // t=41
        en = 1'b0; #1;
        chk("sat_pulses", 32'(n_pulse2), 32'd5);
        chk("stop_req_data", tx_d, 32'hB);
        chk("stop_req_ws", 32'(ws), 32'd0);
        tick();                                   // t=42, STOP
        en = 1'b1; #1;
        chk("stop_valid", 32'(tx_v), 32'd1);
        chk("stop_data", tx_d, 32'd0);
        chk("stop_lrdy", 32'(l_rdy), 32'd0);
        chk("stop_rrdy", 32'(r_rdy), 32'd0);
        chk("stop_busy", 32'(busy), 32'd1);
        repeat (21) tick(); #1;                   // t=63
        chk("stop_end_busy", 32'(busy), 32'd1);
        chk("stop_end_ws", 32'(ws), 32'd1);
        chk("stop_no_ur", 32'(ucnt), 32'd5);
        tick(); #1;                               // t=64, IDLE
        chk("stop_idle_busy", 32'(busy), 32'd0);
        chk("stop_idle_ws", 32'(ws), 32'd0);
        chk("stop_idle_valid", 32'(tx_v), 32'd0);
        chk("ucnt_hold_idle", 32'(ucnt), 32'd5);
        ch2 = 1'b0; wlen = 5'd3; ldata = 32'h21;

        // Mono re-prime with wlen=3
        tick(); #1;
        chk("mono_pL_busy", 32'(busy), 32'd1);
        chk("mono_pL_data", tx_d, 32'h21);
        chk("mono_pL_rrdy", 32'(r_rdy), 32'd0);
        ldata = 32'h22;
        tick(); #1;
        chk("mono_pR_data", tx_d, 32'h22);
        chk("mono_pR_lrdy", 32'(l_rdy), 32'd1);
        chk("mono_pR_rrdy", 32'(r_rdy), 32'd0);
        ldata = 32'h23;
        tick(); #1;                               // RUN u=0
        chk("mono_run0_data", tx_d, 32'h23);
        chk("mono_run0_rrdy", 32'(r_rdy), 32'd0);
        chk("mono_run0_ws", 32'(ws), 32'd0);
        repeat (3) tick(); #1;                    // u=3
        chk("mono_ws_u3", 32'(ws), 32'd0);
        tick(); #1;                               // u=4
        chk("mono_ws_u4", 32'(ws), 32'd1);
        chk("mono_run4_data", tx_d, 32'h23);
        chk("mono_run4_lrdy", 32'(l_rdy), 32'd1);
        chk("mono_run4_rrdy", 32'(r_rdy), 32'd0);
        repeat (3) tick(); #1;                    // u=7
        chk("mono_ws_u7", 32'(ws), 32'd1);
        tick(); #1;                               // u=8
        chk("mono_ws_u8", 32'(ws), 32'd0);
        repeat (4) tick(); #1;                    // u=12
        chk("mono_ws_u12", 32'(ws), 32'd1);

        // Asynchronous reset mid-RUN
        rstn = 1'b0; #1;
        chk("arst_valid", 32'(tx_v), 32'd0);
        chk("arst_data", tx_d, 32'd0);
        chk("arst_lrdy", 32'(l_rdy), 32'd0);
        chk("arst_ws", 32'(ws), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ucnt", 32'(ucnt), 32'd0);
        chk("arst_ucnt2", 32'(ucnt2), 32'd0);
        ch2 = 1'b1; wlen = 5'd15; ldata = 32'hA;
        tick();
        rstn = 1'b1;

        // Abort in PRIME_R
        tick(); #1;
        chk("abort_pL_data", tx_d, 32'hA);
        tick();
        en = 1'b0; #1;
        chk("abort_pR_data", tx_d, 32'hB);
        chk("abort_pR_rrdy", 32'(r_rdy), 32'd1);
        tick(); #1;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_valid", 32'(tx_v), 32'd0);
        chk("abort_idle_rrdy", 32'(r_rdy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2s_tx_scheduler.md
I2S_TX_SCHEDULER -- requirements
Module: i2s_tx_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating underrun counter.
REQ-002 SHALL have ports:
  sck_i  in  1  serial bit clock; all state is on its rising edge
  rstn_i  in  1  reset, asynchronous, active-low
  cfg_en_i  in  1  stream enable
  cfg_2ch_i  in  1  1 = stereo (left/right sources), 0 = mono (left source only)
  cfg_wlen_i  in  5  word length minus 1, in bits
  l_data_i  in  32  left sample
  l_valid_i  in  1  left sample valid
  l_ready_o  out  1  left sample consumed
  r_data_i  in  32  right sample
  r_valid_i  in  1  right sample valid
  r_ready_o  out  1  right sample consumed
  tx_data_o  out  32  word to TX channel
  tx_valid_o  out  1  word valid
  tx_ready_i  in  1  TX channel accepts word
  ws_o  out  1  word select to TX channel; 0 = left slot, 1 = right slot
  underrun_o  out  1  one-cycle pulse per zero word inserted
  underrun_cnt_o  out  CNT_W  saturating underrun count
  busy_o  out  1  state != IDLE

Function
REQ-003 SHALL implement the states IDLE, PRIME_L, PRIME_R, RUN and STOP.
REQ-004 A handshake SHALL be tx_valid_o & tx_ready_i in the same cycle.
REQ-005 The selected source SHALL be left when cfg_2ch_i=0; otherwise it SHALL be given by r_sel (0 = left, 1 = right).
REQ-006 r_sel SHALL toggle on every handshake in RUN and in PRIME when cfg_2ch_i=1, and SHALL be cleared in IDLE.
REQ-007 IDLE: tx_valid_o=0, l_ready_o=r_ready_o=0, ws_o=0, bit counter=0; cfg_en_i=1 -> PRIME_L.
REQ-008 PRIME_L/PRIME_R: tx_valid_o SHALL equal the selected source valid, and tx_data_o SHALL equal the selected source data.
REQ-009 PRIME_L/PRIME_R: the selected ready SHALL equal tx_ready_i; the unselected ready SHALL be 0; no zero words SHALL be inserted.
REQ-010 A handshake in PRIME_L SHALL go to PRIME_R; a handshake in PRIME_R SHALL go to RUN with the bit counter cleared and ws_o=0.
REQ-011 cfg_en_i=0 in PRIME_L or PRIME_R SHALL go to IDLE the next cycle, discarding progress; words already handed over are not recalled.
REQ-012 RUN: tx_valid_o SHALL be 1.
REQ-013 RUN, selected source valid: tx_data_o SHALL equal the source data, and the source ready SHALL equal tx_ready_i.
REQ-014 RUN, selected source not valid: tx_data_o SHALL be 0 and both readies SHALL be 0.
REQ-015 A handshake of a zero word in RUN SHALL pulse underrun_o one cycle later and increment underrun_cnt_o, saturating at all-ones.
REQ-016 WS generator in RUN and STOP: the bit counter SHALL count 0..cfg_wlen_i and wrap to 0.
REQ-017 WS generator: ws_o SHALL toggle on the cycle the counter equals cfg_wlen_i, giving a ws_o period of 2*(cfg_wlen_i+1) sck cycles in both modes.
REQ-018 RUN with cfg_en_i=0 SHALL go to STOP.
REQ-019 STOP: tx_valid_o SHALL be 1, tx_data_o SHALL be 0, both readies SHALL be 0, and no underrun SHALL be counted.
REQ-020 STOP SHALL go to IDLE on the cycle the counter equals cfg_wlen_i and ws_o=1 (end of right slot); ws_o SHALL then be 0.
REQ-021 cfg_en_i returning to 1 in STOP SHALL be ignored until IDLE is reached; re-priming then starts the next cycle.
REQ-022 cfg_2ch_i and cfg_wlen_i SHALL be sampled only while in IDLE and held internally until the next return to IDLE.
REQ-023 underrun_cnt_o SHALL clear only on reset; it SHALL hold across IDLE.
REQ-024 l_ready_o and r_ready_o SHALL never both be 1 in the same cycle.
REQ-025 In mono, r_ready_o SHALL be 0 at all times.

Reset
REQ-026 rstn_i=0 SHALL asynchronously force: state IDLE; tx_valid_o=0; tx_data_o=0; l_ready_o=0; r_ready_o=0; ws_o=0; underrun_o=0; underrun_cnt_o=0; busy_o=0; r_sel=0; bit counter=0.
REQ-027 Reset asserted mid-RUN SHALL take effect immediately, with no frame completion.

Verification
REQ-028 Stereo prime: en=1, 2ch=1, wlen=15, L=0xA, R=0xB valid, tx_ready=1 -> 0xA then 0xB handed over; RUN entered; ws_o first rises 16 cycles later, period 32.
REQ-029 Underrun: in RUN, right source idle at its slot -> tx_data_o=0 accepted; underrun_o pulses once; underrun_cnt_o=1; the next left word is taken from l_data_i.
REQ-030 Saturation: CNT_W=2, force 5 underruns -> underrun_cnt_o=3, with 5 underrun_o pulses.
REQ-031 Stop: en drops while ws_o=0 in RUN -> zero words supplied; IDLE entered at end of the following right slot; busy_o falls; ws_o=0.
REQ-032 Mono: 2ch=0 -> both prime words and all RUN words come from left; r_ready_o stays 0; ws_o still toggles every wlen+1 cycles.
REQ-033 Abort/reset: en=0 in PRIME_R -> IDLE next cycle; rstn_i pulse in RUN -> all outputs at reset values in the same cycle.
